sm4_iter_core: RTL
==================

# sm4_iter_core

Iterative SM4 block-cipher engine that extends the standalone round-function and key-expansion steps into a complete core. It expands a 128-bit master key into a stored round-key file, then encrypts or decrypts 128-bit blocks on request, one round at a time. One shared T/T′ datapath with four clocked S_BOX instances serves both key expansion and data rounds. It sits between the host register interface and the block-mode logic.

## Interface
- ROUNDS, 32, number of rounds (1..32). Use 32 for standard SM4; smaller values are for reduced-round testing only.
- CLK  in  1  single clock
- RST  in  1  synchronous reset, active-high
- KEY_VALID  in  1  master key offered
- KEY_READY  out  1  key accepted when KEY_VALID && KEY_READY
- KEY  in  128  master key MK0..MK3, with MK0 in [127:96]
- KEY_LOADED  out  1  round-key file valid
- IN_VALID  in  1  block offered
- IN_READY  out  1  block accepted when IN_VALID && IN_READY
- IN_DEC  in  1  sampled with the block: 1 = decrypt, 0 = encrypt
- IN_DATA  in  128  X0..X3, with X0 in [127:96]
- OUT_VALID  out  1  result available
- OUT_READY  in  1  result consumed when OUT_VALID && OUT_READY
- OUT_DATA  out  128  result block
- BUSY  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, KEY_S, KEY_U, DAT_S, DAT_U, DONE.
  - "S" phase: the XOR of words 1..3 and the constant/key is presented to the S-boxes. The clocked S_BOX has 1-cycle read latency.
  - "U" phase: the S-box output is available. The linear transform is applied, the new word is computed, the 4-word state shifts left by one word, and the round counter r increments.
- Key expansion (IDLE → KEY_S on key handshake):
  - Load K = MK ^ FK.
  - Each U phase computes K[r+4] = K[r] ^ L′(τ(K[r+1]^K[r+2]^K[r+3]^CK[r])), where L′(B) = B ^ (B<<<13) ^ (B<<<23).
  - The result is written to rk[r].
  - After round ROUNDS−1: go to IDLE and set KEY_LOADED = 1.
- Data (IDLE → DAT_S on block handshake):
  - Load X from IN_DATA and latch IN_DEC.
  - Each U phase computes X[r+4] = X[r] ^ L(τ(X[r+1]^X[r+2]^X[r+3]^rk_sel)), where L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24).
  - rk_sel = rk[r] when encrypting, rk[ROUNDS−1−r] when decrypting.
  - After round ROUNDS−1: go to DONE with OUT_DATA = {W3, W2, W1, W0}, i.e. the final 4-word state in reversed word order.
- DONE: OUT_VALID = 1. On OUT_READY, go to IDLE.
- Handshake rules:
  - KEY_READY = (state == IDLE).
  - IN_READY = (state == IDLE) && KEY_LOADED && !KEY_VALID, so a key offered in the same cycle as a block wins.
  - Accepting a new key clears KEY_LOADED at the acceptance edge.
- Round counter: 5 bits. Exit test is r == ROUNDS−1 in the U phase. The counter resets to 0 on every start.

## Timing
- Reset values: state IDLE, KEY_READY 1, KEY_LOADED 0, IN_READY 0, OUT_VALID 0, OUT_DATA 0, BUSY 0. Round-key file contents are don't-care after reset.
- RST in any state, including mid-expansion or mid-block: returns to IDLE on the next edge. KEY_LOADED = 0 and any in-flight result is discarded.
- Key expansion: 2·ROUNDS cycles from the acceptance edge to KEY_LOADED = 1 (64 cycles for ROUNDS = 32).
- Block latency: OUT_VALID rises 2·ROUNDS cycles after the acceptance edge (64 cycles for ROUNDS = 32).
- While OUT_VALID && !OUT_READY: OUT_DATA is held stable and IN_READY stays 0.
- OUT_VALID falls on the edge after the output handshake. The next block can be accepted one cycle later, so back-to-back throughput is 1 block per 2·ROUNDS+2 cycles.
- IN_DEC is used only as sampled at acceptance. Later changes have no effect.

## Structure
- Package sm4_pkg holds:
  - FK constants (A3B1BAC6, 56AA3350, 677D9197, B27022DC).
  - A function ck(i) returning CK[i]: byte j = (4i+j)·7 mod 256, first byte in the MSB.
  - The state enum.
  - Rotate helpers for L and L′.
- Sub-module sm4_tround: 4× S_BOX plus a mode-selected linear transform (mode 0 = L, mode 1 = L′). Inputs: CLK, X0..X3, KC (constant or round key), MODE. Output: the new word.
- rk file: 32×32 registers, written in KEY_U only.

## Test plan
- Key expansion, ROUNDS = 32: KEY = 0123456789abcdeffedcba9876543210 → KEY_LOADED 64 cycles after acceptance; rk[0] = f12186f9, rk[31] = 9124a012.
- Encrypt: IN_DATA = 0123456789abcdeffedcba9876543210, IN_DEC = 0 → OUT_VALID after 64 cycles with OUT_DATA = 681edf34d206965e86b3e94f536e4246.
- Decrypt: IN_DATA = 681edf34d206965e86b3e94f536e4246, IN_DEC = 1 → OUT_DATA = 0123456789abcdeffedcba9876543210.
- Backpressure: hold OUT_READY = 0 for 10 cycles → OUT_DATA stable, IN_READY = 0 throughout. Release → OUT_VALID falls on the next edge, then IN_READY = 1.
- Simultaneous KEY_VALID and IN_VALID in IDLE → key accepted, block not accepted (IN_READY = 0), KEY_LOADED = 0 until the new expansion completes.
- RST asserted at round 10 of expansion → IDLE next cycle, KEY_LOADED = 0, IN_READY = 0. A reload then reproduces the known vectors.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: FSM states, FK/CK constants, S-box table and
// the two linear transforms used by the round datapath.
package sm4_pkg;

    typedef enum logic [2:0] {IDLE, KEY_S, KEY_U, DAT_S, DAT_U, DONE} state_t;

    localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fe_cce13db7_16b614c2_28fb2c05, 128'h2b679a76_2abe04c3_aa441326_49860699,
        128'h9c4250f4_91ef987a_33540b43_edcfac62, 128'he4b31ca9_c908e895_80df94fa_758f3fa6,
        128'h4707a7fc_f37317ba_83593c19_e6854fa8, 128'h686b81b2_7164da8b_f8eb0f4b_70569d35,
        128'h1e240e5e_6358d1a2_25227c3b_01217887, 128'hd4004657_9fd32752_4c3602e7_a0c4c89e,
        128'heabf8ad2_40c738b5_a3f7f2ce_f96115a1, 128'he0ae5da4_9b341a55_ad933230_f58cb1e3,
        128'h1df6e22e_8266ca60_c02923ab_0d534e6f, 128'hd5db3745_defd8e2f_03ff6a72_6d6c5b51,
        128'h8d1baf92_bbddbc7f_11d95c41_1f105ad8, 128'h0ac13188_a5cd7bbd_2d74d012_b8e5b4b0,
        128'h8969974a_0c96777e_65b9f109_c56ec684, 128'h18f07dec_3adc4d20_79ee5f3e_d7cb3948
    };

    // CK[i]: byte j is (4i+j)*7 mod 256, byte 0 in the MSB.
    function automatic logic [31:0] ck(input logic [4:0] i);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < 4; j++) v[31-8*j -: 8] = 8'((4 * int'(i) + j) * 7);
        return v;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] lin_data(input logic [31:0] b);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] lin_key(input logic [31:0] b);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

endpackage

// File: rtl/sm4_iter_core_if.sv
// Host-side handshake bundle for sm4_iter_core: key load, block in, result out.
interface sm4_iter_core_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         key_loaded;
    logic         in_valid;
    logic         in_ready;
    logic         in_dec;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output key_valid, key, in_valid, in_dec, in_data, out_ready,
        input  key_ready, key_loaded, in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  key_valid, key, in_valid, in_dec, in_data, out_ready,
        output key_ready, key_loaded, in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sm4_tround.sv
// One SM4 round word: four clocked S-box lookups, then L (mode 0) or L' (mode 1)
// XORed into X0. Output is valid the cycle after the XOR input is presented.
module sm4_tround
    import sm4_pkg::*;
(
    input  logic        clk,
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    input  logic [31:0] kc,
    input  logic        mode,
    output logic [31:0] y
);
    logic [31:0] sbox_in;
    logic [31:0] sbox_q;

    assign sbox_in = x1 ^ x2 ^ x3 ^ kc;

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        logic [7:0] q;
        // NOTE: lookup and storage registers have no reset; they are always written before being read.
        always_ff @(posedge clk) q <= SBOX[sbox_in[8*i +: 8]];
        assign sbox_q[8*i +: 8] = q;
    end

    assign y = x0 ^ (mode ? lin_key(sbox_q) : lin_data(sbox_q));
endmodule

// File: rtl/sm4_iter_core.sv
// Iterative SM4 engine: expands a master key into a round-key file, then runs
// blocks one round per two cycles (S-box phase, update phase) on a shared datapath.
module sm4_iter_core
    import sm4_pkg::*;
#(
    parameter int ROUNDS = 32
) (
    input logic            clk,
    input logic            rst,
    sm4_iter_core_if.slave bus
);
    state_t       state, state_n;
    logic [4:0]   r;
    logic [127:0] w;
    logic         dec;
    logic         key_loaded;
    logic [127:0] out_data;
    logic [31:0]  rk_file [32];
    logic [31:0]  rk_sel, kc, new_word;
    logic         key_phase, last, in_ready, key_acc, blk_acc;

    assign key_phase = (state == KEY_S) || (state == KEY_U);
    assign last      = (r == 5'(ROUNDS - 1));
    assign in_ready  = (state == IDLE) && key_loaded && !bus.key_valid;
    assign key_acc   = (state == IDLE) && bus.key_valid;
    assign blk_acc   = in_ready && bus.in_valid;

    assign rk_sel = dec ? rk_file[5'(ROUNDS - 1) - r] : rk_file[r];
    assign kc     = key_phase ? ck(r) : rk_sel;

    sm4_tround u_tround (
        .clk  (clk),
        .x0   (w[127:96]),
        .x1   (w[95:64]),
        .x2   (w[63:32]),
        .x3   (w[31:0]),
        .kc   (kc),
        .mode (key_phase),
        .y    (new_word)
    );

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_n and no latch is inferred.
        state_n = state;
        case (state)
            IDLE:    if (key_acc) state_n = KEY_S;
                     else if (blk_acc) state_n = DAT_S;
            KEY_S:   state_n = KEY_U;
            KEY_U:   state_n = last ? IDLE : KEY_S;
            DAT_S:   state_n = DAT_U;
            DAT_U:   state_n = last ? DONE : DAT_S;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r          <= '0;
            w          <= '0;
            dec        <= 1'b0;
            key_loaded <= 1'b0;
            out_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_acc) begin
                        w          <= bus.key ^ FK;
                        r          <= '0;
                        key_loaded <= 1'b0;
                    end else if (blk_acc) begin
                        w   <= bus.in_data;
                        dec <= bus.in_dec;
                        r   <= '0;
                    end
                end
                KEY_U, DAT_U: begin
                    w <= {w[95:0], new_word};
                    r <= r + 5'd1;
                    if (last && state == KEY_U) key_loaded <= 1'b1;
                    // Output is the final four words in reversed order.
                    if (last && state == DAT_U) out_data <= {new_word, w[31:0], w[63:32], w[95:64]};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == KEY_U) rk_file[r] <= new_word;
    end

    assign bus.key_ready  = (state == IDLE);
    assign bus.key_loaded = key_loaded;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state == DONE);
    assign bus.out_data   = out_data;
    assign bus.busy       = (state != IDLE);
endmodule
